// File: rtl/cam_crop_xy_gen.sv
// rtl/cam_crop_xy_gen.sv - sensor stream to cropped x/y pixel stream for the scaler
//
// Purpose: locks to sensor frame-valid edges, counts raw columns/lines, keeps
// the X_START/Y_START window of X_TOTAL x Y_TOTAL pixels and emits them with
// explicit coordinates one cycle after the input sample. Short lines and
// short frames are flagged with one-cycle pulses.
//
// Ports:
//   in_pclk, in_arstn                 pixel clock, synchronous active-low reset
//   in_frame_valid, in_line_valid     sensor framing
//   in_data_valid, in_data            sensor pixel qualifier and data
//   in_pattern_sel                    test pattern select (CAM_CROP_TEST_PATTERN_EN only)
//   out_x, out_y, out_valid, out_data cropped pixel with coordinates
//   out_frame_start, out_frame_end    frame markers
//   err_line_short, err_frame_short   malformed line/frame pulses
//
// Optional feature macro: CAM_CROP_TEST_PATTERN_EN adds in_pattern_sel, which
// replaces out_data with (out_x ^ out_y) sized to P_DEPTH.

module cam_crop_xy_gen #(
   parameter int P_DEPTH = 10,
   parameter int X_START = 0,
   parameter int Y_START = 0,
   parameter int X_TOTAL = 1280,
   parameter int Y_TOTAL = 720
) (
   input  logic               in_pclk,
   input  logic               in_arstn,
   input  logic               in_frame_valid,
   input  logic               in_line_valid,
   input  logic               in_data_valid,
   input  logic [P_DEPTH-1:0] in_data,
`ifdef CAM_CROP_TEST_PATTERN_EN
   input  logic               in_pattern_sel,
`endif
   output logic [10:0]        out_x,
   output logic [10:0]        out_y,
   output logic               out_valid,
   output logic [P_DEPTH-1:0] out_data,
   output logic               out_frame_start,
   output logic               out_frame_end,
   output logic               err_line_short,
   output logic               err_frame_short
);

   // 12-bit window bounds so that a window ending at 2048 does not wrap
   localparam logic [11:0] XS = 12'(X_START);
   localparam logic [11:0] XE = 12'(X_START + X_TOTAL);
   localparam logic [11:0] YS = 12'(Y_START);
   localparam logic [11:0] YE = 12'(Y_START + Y_TOTAL);

   typedef enum logic [2:0] {
      S_UNLOCKED,
      S_WAIT_LINE,
      S_IN_LINE,
      S_FRAME_END,
      S_WAIT_FV
   } state_t;

   state_t state, state_nxt;

   logic               fv_q, lv_q;
   logic [10:0]        cx, cy;
   logic [10:0]        col;
   logic               fv_rise, line_start, in_line, line_end;
   logic               win_y, keep, short_line;
   logic [10:0]        x_nxt, y_nxt;
   logic [P_DEPTH-1:0] data_nxt;

   // State register
   always_ff @(posedge in_pclk) begin
      if (!in_arstn) state <= S_UNLOCKED;
      else           state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_UNLOCKED:  if (fv_rise) state_nxt = S_WAIT_LINE;
         S_WAIT_LINE: begin
            if (!in_frame_valid) state_nxt = S_FRAME_END;
            else if (line_start) state_nxt = S_IN_LINE;
         end
         // A frame-valid fall mid-line closes the line first, frame end follows
         S_IN_LINE:   if (line_end) state_nxt = in_frame_valid ? S_WAIT_LINE : S_FRAME_END;
         S_FRAME_END: state_nxt = S_WAIT_FV;
         S_WAIT_FV:   if (fv_rise) state_nxt = S_WAIT_LINE;
         default:     state_nxt = S_UNLOCKED;
      endcase
   end

   // Output logic: frame-level pulses are decoded straight from the state
   always_comb begin
      out_frame_end   = (state == S_FRAME_END);
      err_frame_short = (state == S_FRAME_END) && ({1'b0, cy} < YE);
   end

   // Pixel path decode. The first pixel of a line arrives on the same cycle
   // as the line-valid rise, so it is taken at column 0 from WAIT_LINE.
   always_comb begin
      fv_rise    = in_frame_valid && !fv_q;
      col        = (state == S_IN_LINE) ? cx : 11'd0;
      line_start = (state == S_WAIT_LINE) && in_frame_valid && in_line_valid && !lv_q;
      in_line    = (state == S_IN_LINE) && in_frame_valid && in_line_valid;
      line_end   = (state == S_IN_LINE) && !(in_frame_valid && in_line_valid);
      win_y      = ({1'b0, cy} >= YS) && ({1'b0, cy} < YE);
      keep       = (line_start || in_line) && in_data_valid && win_y &&
                   ({1'b0, col} >= XS) && ({1'b0, col} < XE);
      short_line = line_end && win_y && ({1'b0, cx} < XE);
      x_nxt      = col - XS[10:0];
      y_nxt      = cy - YS[10:0];
`ifdef CAM_CROP_TEST_PATTERN_EN
      data_nxt   = in_pattern_sel ? P_DEPTH'({{P_DEPTH{1'b0}}, x_nxt ^ y_nxt}) : in_data;
`else
      data_nxt   = in_data;
`endif
   end

   // Counters and registered pixel outputs. fv_q resets high so that a reset
   // released inside a frame does not see a false rising edge.
   always_ff @(posedge in_pclk) begin
      if (!in_arstn) begin
         fv_q            <= 1'b1;
         lv_q            <= 1'b0;
         cx              <= '0;
         cy              <= '0;
         out_x           <= '0;
         out_y           <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_frame_start <= 1'b0;
         err_line_short  <= 1'b0;
      end else begin
         fv_q            <= in_frame_valid;
         lv_q            <= in_line_valid;
         out_valid       <= keep;
         out_frame_start <= keep && ({1'b0, col} == XS) && ({1'b0, cy} == YS);
         err_line_short  <= short_line;
         if (keep) begin
            out_x    <= x_nxt;
            out_y    <= y_nxt;
            out_data <= data_nxt;
         end
         if (line_start)
            cx <= in_data_valid ? 11'd1 : 11'd0;
         else if (in_line && in_data_valid && cx != 11'h7FF)
            cx <= cx + 11'd1;
         if (line_end && cy != 11'h7FF)
            cy <= cy + 11'd1;
         else if (state == S_FRAME_END)
            cy <= '0;
      end
   end

endmodule

// File: tb/tb_cam_crop_xy_gen.sv
// tb/tb_cam_crop_xy_gen.sv - self-checking bench for cam_crop_xy_gen
module tb_cam_crop_xy_gen;

   localparam int XS = 4;
   localparam int YS = 2;
   localparam int XT = 8;
   localparam int YT = 4;
   localparam int SW = 16;
   localparam int SH = 8;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [9:0]  d;
      logic        fs;
   } exp_t;

   logic        clk = 1'b0;
   logic        in_arstn, fv, lv, dv;
   logic [9:0]  d;
   logic [10:0] out_x, out_y;
   logic        out_valid;
   logic [9:0]  out_data;
   logic        out_frame_start, out_frame_end, err_line_short, err_frame_short;

   int   checks = 0;
   int   errors = 0;
   int   ov_cnt, fs_cnt, fe_cnt, els_cnt, efs_cnt, exp_els;
   bit   locked;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   cam_crop_xy_gen #(
      .P_DEPTH(10), .X_START(XS), .Y_START(YS), .X_TOTAL(XT), .Y_TOTAL(YT)
   ) dut (
      .in_pclk(clk),
      .in_arstn(in_arstn),
      .in_frame_valid(fv),
      .in_line_valid(lv),
      .in_data_valid(dv),
      .in_data(d),
`ifdef CAM_CROP_TEST_PATTERN_EN
      .in_pattern_sel(1'b0),
`endif
      .out_x(out_x),
      .out_y(out_y),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_frame_start(out_frame_start),
      .out_frame_end(out_frame_end),
      .err_line_short(err_line_short),
      .err_frame_short(err_frame_short)
   );

   // Raw sensor pixel value; raw (col 4, line 2) is 0x155
   function automatic logic [9:0] pix(input int l, input int c);
      return 10'(341 + l * 16 + c - 36);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      ov_cnt = 0; fs_cnt = 0; fe_cnt = 0; els_cnt = 0; efs_cnt = 0; exp_els = 0;
   endtask

   // Scoreboard: pop and compare every strobe on the falling edge
   always @(negedge clk) begin
      if (out_frame_start) fs_cnt++;
      if (out_frame_end)   fe_cnt++;
      if (err_line_short)  els_cnt++;
      if (err_frame_short) begin
         efs_cnt++;
         checks++;
         if (out_frame_end !== 1'b1) begin
            errors++;
            $display("FAIL frame_short_coincide out_frame_end=%b required 1", out_frame_end);
         end
      end
      if (out_valid === 1'b1) begin
         ov_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected strobe x=%0d y=%0d required no strobe", out_x, out_y);
         end else begin
            e = sb.pop_front();
            if ({out_x, out_y, out_data, out_frame_start} !== e) begin
               errors++;
               $display("FAIL sb_pixel x=%0d y=%0d d=%h fs=%b required x=%0d y=%0d d=%h fs=%b",
                        out_x, out_y, out_data, out_frame_start, e.x, e.y, e.d, e.fs);
            end
         end
      end
   end

   task automatic send_line(input int l, input int len, input bit gaps, input int rst_col);
      int col = 0;
      int t = 0;
      bit kept;
      bit rst_now;
      lv = 1'b1;
      while (col < len) begin
         dv      = gaps ? t[0] : 1'b1;
         d       = pix(l, col);
         rst_now = (col == rst_col) && (in_arstn == 1'b1);
         kept    = locked && dv && col >= XS && col < XS + XT && l >= YS && l < YS + YT;
         if (rst_now) begin
            in_arstn = 1'b0;
            kept     = 1'b0;
         end
         if (kept)
            sb.push_back('{x: 11'(col - XS), y: 11'(l - YS), d: pix(l, col),
                           fs: (col == XS && l == YS)});
         tick();
         if (rst_now) begin
            checks++;
            if ({out_valid, out_x, out_y, out_data, out_frame_start, out_frame_end,
                 err_line_short, err_frame_short} !== '0) begin
               errors++;
               $display("FAIL reset_midline v=%b x=%0d y=%0d d=%h pulses=%b%b%b%b required all 0",
                        out_valid, out_x, out_y, out_data, out_frame_start, out_frame_end,
                        err_line_short, err_frame_short);
            end
            in_arstn = 1'b1;
            locked   = 1'b0;
         end
         checks++;
         if (out_valid !== kept) begin
            errors++;
            $display("FAIL pixel_valid line=%0d col=%0d out_valid=%b required %b", l, col, out_valid, kept);
         end
         if (dv) col++;
         t++;
      end
      if (locked && l >= YS && l < YS + YT && len < XS + XT) exp_els++;
      lv = 1'b0;
      dv = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_frame(input int nlines, input bit lock, input int cut_line, input int cut_len,
                             input bit gaps, input int rst_line, input int rst_col);
      bit exp_fe, exp_efs;
      locked = lock;
      fv = 1'b1; lv = 1'b0; dv = 1'b0;
      tick();
      tick();
      for (int l = 0; l < nlines; l++)
         send_line(l, (l == cut_line) ? cut_len : SW, gaps, (l == rst_line) ? rst_col : -1);
      exp_fe  = locked;
      exp_efs = locked && (nlines < YS + YT);
      fv = 1'b0;
      tick();
      checks++;
      if (out_frame_end !== exp_fe) begin
         errors++;
         $display("FAIL frame_end_timing out_frame_end=%b required %b", out_frame_end, exp_fe);
      end
      checks++;
      if (err_frame_short !== exp_efs) begin
         errors++;
         $display("FAIL frame_short_timing err_frame_short=%b required %b", err_frame_short, exp_efs);
      end
      tick(); tick(); tick();
      locked = 1'b0;
   endtask

   task automatic test_reset();
      in_arstn = 1'b0; fv = 1'b1; lv = 1'b0; dv = 1'b0; d = '0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required 0", out_valid); end
      checks++;
      if ({out_x, out_y} !== 22'd0) begin errors++; $display("FAIL reset_xy x=%0d y=%0d required 0", out_x, out_y); end
      checks++;
      if (out_data !== 10'd0) begin errors++; $display("FAIL reset_data got=%h required 0", out_data); end
      checks++;
      if ({out_frame_start, out_frame_end, err_line_short, err_frame_short} !== 4'd0) begin
         errors++;
         $display("FAIL reset_pulses got=%b required 0000",
                  {out_frame_start, out_frame_end, err_line_short, err_frame_short});
      end
      in_arstn = 1'b1;
   endtask

   task automatic test_two_frames();
      clear_counts();
      send_frame(SH, 1'b0, -1, 0, 1'b0, -1, -1);
      checks++;
      if (ov_cnt !== 0 || fe_cnt !== 0) begin
         errors++; $display("FAIL unlocked_frame strobes=%0d frame_end=%0d required 0 0", ov_cnt, fe_cnt);
      end
      clear_counts();
      send_frame(SH, 1'b1, -1, 0, 1'b0, -1, -1);
      checks++;
      if (ov_cnt !== 32) begin errors++; $display("FAIL full_frame_strobes got=%0d required 32", ov_cnt); end
      checks++;
      if (fs_cnt !== 1) begin errors++; $display("FAIL frame_start_count got=%0d required 1", fs_cnt); end
      checks++;
      if (els_cnt !== 0 || efs_cnt !== 0) begin
         errors++; $display("FAIL full_frame_errors line=%0d frame=%0d required 0 0", els_cnt, efs_cnt);
      end
   endtask

   task automatic test_short_line();
      clear_counts();
      send_frame(SH, 1'b1, 3, 9, 1'b0, -1, -1);
      checks++;
      if (els_cnt !== exp_els || exp_els !== 1) begin
         errors++; $display("FAIL short_line_count got=%0d required %0d", els_cnt, exp_els);
      end
      checks++;
      if (ov_cnt !== 29) begin errors++; $display("FAIL short_line_strobes got=%0d required 29", ov_cnt); end
   endtask

   task automatic test_short_frame();
      clear_counts();
      send_frame(4, 1'b1, -1, 0, 1'b0, -1, -1);
      checks++;
      if (efs_cnt !== 1 || ov_cnt !== 16) begin
         errors++; $display("FAIL short_frame err=%0d strobes=%0d required 1 16", efs_cnt, ov_cnt);
      end
      clear_counts();
      send_frame(SH, 1'b1, -1, 0, 1'b0, -1, -1);
      checks++;
      if (efs_cnt !== 0 || els_cnt !== 0 || ov_cnt !== 32) begin
         errors++;
         $display("FAIL after_short_frame efs=%0d els=%0d strobes=%0d required 0 0 32", efs_cnt, els_cnt, ov_cnt);
      end
   endtask

   task automatic test_gaps();
      clear_counts();
      send_frame(SH, 1'b1, -1, 0, 1'b1, -1, -1);
      checks++;
      if (ov_cnt !== 32 || els_cnt !== 0) begin
         errors++; $display("FAIL gaps_strobes got=%0d els=%0d required 32 0", ov_cnt, els_cnt);
      end
   endtask

   task automatic test_midline_reset();
      clear_counts();
      send_frame(SH, 1'b1, -1, 0, 1'b0, 2, 6);
      checks++;
      if (ov_cnt !== 2 || fe_cnt !== 0) begin
         errors++; $display("FAIL midline_reset strobes=%0d frame_end=%0d required 2 0", ov_cnt, fe_cnt);
      end
      clear_counts();
      send_frame(SH, 1'b1, -1, 0, 1'b0, -1, -1);
      checks++;
      if (ov_cnt !== 32 || fs_cnt !== 1) begin
         errors++; $display("FAIL relock_frame strobes=%0d fs=%0d required 32 1", ov_cnt, fs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_two_frames();
      test_short_line();
      test_short_frame();
      test_gaps();
      test_midline_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover entries=%0d required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_crop_xy_gen.md
Name: cam_crop_xy_gen

Overview:
Upstream neighbour of the camera scaler. Converts the raw sensor stream (frame valid, line valid, pixel valid, pixel data) into the scaler's input contract: a cropped window with explicit x/y coordinates and a pixel-valid strobe. Frames are locked to frame-valid edges, and malformed lines and frames are flagged. One pixel clock domain; there is no backpressure.

Parameters:
P_DEPTH, 10, pixel data width
X_START, 0, first kept input column (0..2046)
Y_START, 0, first kept input line (0..2046)
X_TOTAL, 1280, kept columns per line; output x runs 0..X_TOTAL-1
Y_TOTAL, 720, kept lines per frame; output y runs 0..Y_TOTAL-1

Ports:
in_pclk  in  1  pixel clock
in_arstn  in  1  reset; synchronous, active-low
in_frame_valid  in  1  sensor frame valid; high for the whole frame
in_line_valid  in  1  sensor line valid; high for the whole line
in_data_valid  in  1  pixel qualifier; only counted while in_line_valid is high
in_data  in  P_DEPTH  sensor pixel
out_x  out  11  cropped column
out_y  out  11  cropped line
out_valid  out  1  pixel strobe for out_x, out_y and out_data
out_data  out  P_DEPTH  pixel
out_frame_start  out  1  one-cycle pulse coincident with the pixel at (0,0)
out_frame_end  out  1  one-cycle pulse on the cycle after in_frame_valid falls in a locked frame
err_line_short  out  1  one-cycle pulse: a window line ended before column X_START+X_TOTAL
err_frame_short  out  1  one-cycle pulse: a frame ended before line Y_START+Y_TOTAL

Behaviour:
- Reset (in_arstn low at a rising edge): every output is 0, all counters are 0, state = UNLOCKED.
- State UNLOCKED
  - Ignores all input.
  - On in_frame_valid 0->1 (edge seen from a registered copy): go to WAIT_LINE.
  - A reset released mid-frame therefore discards the rest of that frame.
- State WAIT_LINE
  - On in_line_valid 0->1: go to IN_LINE and clear the raw column counter cx.
  - On in_frame_valid 1->0: go to FRAME_END.
- State IN_LINE
  - Each cycle with in_line_valid && in_data_valid increments cx; cx saturates at 2047.
  - A pixel is kept when X_START <= cx < X_START+X_TOTAL and Y_START <= cy < Y_START+Y_TOTAL, where cy is the raw line counter.
  - Kept pixels drive out_valid=1, out_x=cx-X_START, out_y=cy-Y_START, out_data=in_data.
  - Latency: exactly 1 cycle from the input sample to the registered output.
  - On in_line_valid 1->0:
    - cy increments; it saturates at 2047.
    - If cy was inside the window and cx < X_START+X_TOTAL, pulse err_line_short.
    - Return to WAIT_LINE.
  - Pixels beyond the window are dropped silently; there is no error for a long line.
- State FRAME_END (one cycle)
  - Pulse out_frame_end.
  - If cy < Y_START+Y_TOTAL, pulse err_frame_short in the same cycle.
  - Clear cy, then go to WAIT_FV.
- State WAIT_FV: on in_frame_valid 0->1, go to WAIT_LINE.
- in_frame_valid falling while in IN_LINE: treat as end of line (same-cycle error checks), then FRAME_END on the next cycle.
- out_frame_start is asserted with the first kept pixel whose out_x=0 and out_y=0.
- out_valid is 0 in every cycle without a kept pixel. out_x, out_y and out_data hold their last value while out_valid is 0.
- Comparisons use 12-bit unsigned arithmetic, so X_START+X_TOTAL = 2048 does not overflow.

Optional Feature:
- Macro: CAM_CROP_TEST_PATTERN_EN.
- When defined:
  - A top-level input port in_pattern_sel (1 bit) is added.
  - When in_pattern_sel is high, out_data = {out_x ^ out_y} truncated or zero-extended to P_DEPTH, replacing the sensor data.
  - All timing is unchanged.
- When not defined: the port does not exist and out_data is always the sensor pixel.

Test Plan:
- Reset release with in_frame_valid already high, then 2 full frames (X_START=4, Y_START=2, X_TOTAL=8, Y_TOTAL=4, sensor 16x8) -> no out_valid in the first frame; the second frame gives exactly 32 strobes with x 0..7 and y 0..3, and out_frame_start on the first of them.
- Sensor pixel at raw (4,2) = 0x155 -> out_valid with out_x=0, out_y=0, out_data=0x155 one cycle later; out_frame_start is high in that same cycle.
- Line 3 (raw) cut after 9 valid pixels -> err_line_short pulses once on the line_valid fall; out_y for that line still advances to the next line normally.
- Frame with only 4 raw lines -> err_frame_short and out_frame_end pulse together one cycle after the frame_valid fall; the next full frame has no errors.
- in_data_valid gaps (toggling every other cycle) inside a line -> out_x stays contiguous 0..7 and out_valid is low in the gap cycles.
- in_arstn asserted mid-line for 1 cycle -> all outputs are 0 next cycle; no output until the following frame_valid rising edge.
